// File: rtl/stream_mux_pkg.sv
// Shared types and sizing helpers for the N-input stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_WAIT   = 1'b1
    } mux_state_t;

    localparam int CNT_W = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tmo_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_fifo.sv
// First-word-fallthrough FIFO for one input channel; writes into a full FIFO are dropped and flagged.
module stream_mux_n_fifo #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push_vld,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          one,
    output logic          drop
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, push;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one   = ((wr_ptr - rd_ptr) == (AW+1)'(1));
    assign push  = push_vld & ~full;
    assign drop  = push_vld & full;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)         wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input AXI-stream round-robin mux with per-channel FWFT FIFOs and packet-atomic grants.
// Define STREAM_MUX_N_DROP_CNT_EN to build the per-channel saturating dropped-word counters.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int DW           = 32,
    parameter int AW           = 8,
    parameter int PACKET_MODE  = 1,
    parameter int TLAST_BIT    = DW - 1,
    parameter int IDLE_TIMEOUT = 10,
    parameter int IDW          = id_w(N_CH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_CH-1:0]       s_tvalid,
    input  logic [N_CH*DW-1:0]    s_tdata,
    input  logic [N_CH-1:0]       s_arb_req_suppress,
    output logic                  m00_tvalid,
    input  logic                  m00_tready,
    output logic [DW-1:0]         m00_tdata,
    output logic [IDW-1:0]        m00_tid,
    output logic [N_CH*CNT_W-1:0] dropped
);

    localparam int             TW       = tmo_w(IDLE_TIMEOUT);
    localparam logic [TW-1:0]  TMO_INIT = TW'(IDLE_TIMEOUT);

    logic [N_CH-1:0][DW-1:0] head;
    logic [N_CH-1:0]         empty, one, drop, pop_ch;
    logic [N_CH-1:0]         in_pkt;
    logic [IDW-1:0]          grant, grant_n, next_ch, rr_idx;
    mux_state_t              state, state_n;
    logic [TW-1:0]           tmo, tmo_n;
    logic                    other_avail, pop, pop_last, empty_g, one_g;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign pop_ch[g] = pop && (grant == IDW'(g));

        stream_mux_n_fifo #(
            .DW(DW),
            .AW(AW)
        ) u_fifo (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .push_vld (s_tvalid[g]),
            .push_data(s_tdata[g*DW +: DW]),
            .pop      (pop_ch[g]),
            .head     (head[g]),
            .empty    (empty[g]),
            .one      (one[g]),
            .drop     (drop[g])
        );
    end

    assign empty_g    = empty[grant];
    assign one_g      = one[grant];
    assign m00_tvalid = ~empty_g;
    assign m00_tdata  = head[grant];
    assign m00_tid    = grant;
    assign pop        = m00_tvalid & m00_tready;
    assign pop_last   = pop & head[grant][TLAST_BIT];

    // Scan grant+1 .. grant+N_CH-1; the granted channel itself is never a rotation target.
    always_comb begin
        next_ch     = grant;
        other_avail = 1'b0;
        rr_idx      = grant;
        for (int k = 1; k < N_CH; k++) begin
            rr_idx = IDW'((int'(grant) + k) % N_CH);
            if (!other_avail && !empty[rr_idx]) begin
                other_avail = 1'b1;
                next_ch     = rr_idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        tmo_n   = TMO_INIT;
        case (state)
            ST_ACTIVE: begin
                if (PACKET_MODE != 0) begin
                    if (pop_last) begin
                        if (other_avail) grant_n = next_ch;
                    end else if (empty_g) begin
                        // Between packets an empty channel yields at once; mid-packet it waits.
                        if (in_pkt[grant])    state_n = ST_WAIT;
                        else if (other_avail) grant_n = next_ch;
                    end
                end else if ((empty_g || (pop && one_g)) && other_avail) begin
                    grant_n = next_ch;
                end
            end
            ST_WAIT: begin
                if (!empty_g) begin
                    state_n = ST_ACTIVE;
                    if (pop_last && other_avail) grant_n = next_ch;
                end else if (tmo == '0) begin
                    if (!s_arb_req_suppress[grant] && other_avail) begin
                        grant_n = next_ch;
                        state_n = ST_ACTIVE;
                    end else begin
                        tmo_n = tmo;
                    end
                end else begin
                    tmo_n = tmo - 1'b1;
                end
            end
            default: state_n = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ST_ACTIVE;
            grant  <= '0;
            tmo    <= TMO_INIT;
            in_pkt <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            tmo   <= tmo_n;
            if (pop) in_pkt[grant] <= ~head[grant][TLAST_BIT];
        end
    end

`ifdef STREAM_MUX_N_DROP_CNT_EN
    logic [N_CH-1:0][CNT_W-1:0] drop_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (drop[k] && (drop_cnt[k] != '1)) drop_cnt[k] <= drop_cnt[k] + 1'b1;
            end
        end
    end

    assign dropped = drop_cnt;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
    assign dropped     = '0;
`endif

endmodule
